// File: rtl/ann_pkg.sv
// ann_pkg: shared widths, FSM state type and saturating clip for the ANN datapath
// sat_clip maps a sign-extended accumulator onto the ACT_W activation range.
package ann_pkg;
    localparam int PROD_W = 19;
    localparam int ACT_W = 20;
    localparam int N_PIXELS = 16;
    localparam int CLIP_W = 64;
    localparam logic signed [CLIP_W-1:0] ACT_MAX = (64'sd1 <<< (ACT_W - 1)) - 64'sd1;
    localparam logic signed [CLIP_W-1:0] ACT_MIN = -ACT_MAX - 64'sd1;

    typedef enum logic [1:0] {ST_ACC, ST_SAT, ST_HOLD} state_e;

    // Returns {clipped, value}.
    function automatic logic [ACT_W:0] sat_clip(input logic signed [CLIP_W-1:0] acc);
        return acc > ACT_MAX ? {1'b1, ACT_MAX[ACT_W-1:0]} :
               acc < ACT_MIN ? {1'b1, ACT_MIN[ACT_W-1:0]} : {1'b0, acc[ACT_W-1:0]};
    endfunction
endpackage

// File: rtl/neuron_accumulator_if.sv
// neuron_accumulator_if: product-in / result-out handshake bundle of one neuron
// master = upstream/downstream environment, slave = the accumulator.
interface neuron_accumulator_if
    import ann_pkg::*;
#(
    parameter int IN_W = PROD_W,
    parameter int OUT_W = ACT_W
);
    logic signed [IN_W-1:0] bias;
    logic signed [IN_W-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic signed [OUT_W-1:0] out_data;
    logic out_valid;
    logic out_ready;
    logic out_sat;

    modport master (
        output bias, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sat
    );
    modport slave (
        input  bias, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sat
    );
endinterface

// File: rtl/neuron_accumulator_sat_clip_unit.sv
// sat_clip_unit: combinational saturation of an ACC_W accumulator to OUT_W with clip flag
// The activation width reuses the shared package function; other widths clip locally.
module sat_clip_unit
    import ann_pkg::*;
#(
    parameter int ACC_W = 25,
    parameter int OUT_W = ACT_W
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] data,
    output logic sat
);
    if (OUT_W == ACT_W) begin : g_pkg
        assign {sat, data} = sat_clip(CLIP_W'(acc));
    end else begin : g_gen
        localparam logic signed [ACC_W-1:0] HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
        localparam logic signed [ACC_W-1:0] LO = -HI - ACC_W'(1);
        assign sat = acc > HI || acc < LO;
        assign data = sat ? (acc < 0 ? LO[OUT_W-1:0] : HI[OUT_W-1:0]) : acc[OUT_W-1:0];
    end
endmodule

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sequential bias + product accumulation with saturated, held result
// Beats are refused outside ACC, so backpressure never loses upstream data.
module neuron_accumulator
    import ann_pkg::*;
#(
    parameter int IN_W = PROD_W,
    parameter int OUT_W = ACT_W,
    parameter int N_INPUTS = N_PIXELS,
    parameter int ACC_W = IN_W + $clog2(N_INPUTS + 1) + 1
) (
    input logic clk,
    input logic rst,
    neuron_accumulator_if.slave io
);
    localparam int CNT_W = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    state_e state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic out_valid_q, out_valid_d;
    logic out_sat_q, out_sat_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [OUT_W-1:0] clip_data;
    logic clip_sat;
    logic beat;

    sat_clip_unit #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_clip (
        .acc(acc_q),
        .data(clip_data),
        .sat(clip_sat)
    );

    assign io.in_ready = state_q == ST_ACC;
    assign io.out_valid = out_valid_q;
    assign io.out_data = out_data_q;
    assign io.out_sat = out_sat_q;
    assign beat = io.in_valid & io.in_ready;

    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d = out_data_q;
        out_sat_d = out_sat_q;
        case (state_q)
            ST_ACC: if (beat) begin
                // First beat of a vector seeds the sum with the bias instead of the old total.
                acc_d = (cnt_q == '0 ? ACC_W'($signed(io.bias)) : acc_q) + ACC_W'($signed(io.in_data));
                cnt_d = cnt_q == LAST ? '0 : cnt_q + CNT_W'(1);
                state_d = cnt_q == LAST ? ST_SAT : ST_ACC;
            end
            ST_SAT: begin
                out_data_d = clip_data;
                out_sat_d = clip_sat;
                out_valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: if (io.out_ready) begin
                out_valid_d = 1'b0;
                acc_d = '0;
                state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q <= '0;
            cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_sat_q <= out_sat_d;
        end
    end
endmodule
